beta_trace_recorder: RTL
========================

# beta_trace_recorder

Captures the Beta processor's per-cycle bus activity (instruction address, data-memory address/write data, MemRead/MemWrite, CPU reset) into 100-bit trace records. Records are buffered in an on-chip FIFO and drained by a host over a valid/ready handshake. It is the writing end of the test-vector format consumed by the Beta bench: every record uses the same packing, `{cntl[3:0], ia, memAddr, memWriteData}`, so captured traces replay directly as golden vectors. It sits beside `beta`, tapping its ports without driving them.

## Interface
- `DEPTH`, 64: FIFO entries; power of two, at least 4.
- `CNT_W`, 16: width of the saturating drop counter.
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `captureEn` in 1: when high, one record is sampled per cycle.
- `clear` in 1: synchronous flush of FIFO, overflow and drop count.
- `cpuReset` in 1: reset value currently applied to `beta`.
- `ia` in 32: Beta instruction address.
- `memAddr` in 32: Beta data address.
- `memWriteData` in 32: Beta write data.
- `MemRead` in 1: Beta data read strobe.
- `MemWrite` in 1: Beta data write strobe.
- `traceData` out 100: head record, packed as `{1'b0, cpuReset, MemRead, MemWrite, ia, memAddr, memWriteData}`.
- `traceValid` out 1: head record is valid.
- `traceReady` in 1: host accepts the head record.
- `count` out $clog2(DEPTH)+1: current occupancy.
- `full` out 1: occupancy equals `DEPTH`.
- `overflow` out 1: sticky; a record was dropped.
- `dropCount` out `CNT_W`: number of dropped records, saturating.

## Operation
- Push condition: `captureEn`, qualified by the filter when it is compiled in (see Configuration).
- A push samples the inputs at the rising edge and writes one record at the tail.
- Pop occurs when `traceValid && traceReady`; the head pointer advances at that edge.
- The FIFO is first-word-fall-through: `traceData` always shows the head entry. `traceData` is don't-care while `traceValid` = 0.
- Push while full with no pop in the same cycle: the record is dropped, `overflow` is set, and `dropCount` increments. `dropCount` saturates at all-ones.
- Push and pop in the same cycle while full: both are accepted and occupancy stays at `DEPTH`. There is no drop.
- Push and pop in the same cycle while empty: the pop is ignored because `traceValid` was 0. The push is accepted.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. Occupancy is tracked with a separate counter.
- `clear` has priority over push and pop in the same cycle. It zeroes pointers, `count`, `overflow` and `dropCount`, and no record is written that cycle.
- Output values after reset: `traceValid` 0, `count` 0, `full` 0, `overflow` 0, `dropCount` 0, `traceData` 0.
- Asserting `reset` mid-drain discards all buffered records immediately, without waiting for a clock edge.

## Timing
- Capture-to-visible latency is 1 cycle. A record pushed at edge N into an empty FIFO gives `traceValid` = 1 after edge N.
- `count`, `full` and `overflow` are registered and reflect the result of the most recent edge.
- Back-to-back drain runs at 1 record per cycle while `traceReady` stays high.
- The host must not rely on `traceData` changing without a pop. The head is stable while `traceValid && !traceReady`.

## Configuration
- `BETA_TRACE_FILTER_EN`
  - Defined: a push occurs only when `captureEn && (MemRead || MemWrite || cpuReset || iaBreak)`. `iaBreak` is high when `ia` ≠ previous-cycle `ia` + 4. The previous-cycle `ia` register resets to 0x0000_0000 and is updated every cycle regardless of `captureEn`.
  - Not defined: every `captureEn` cycle is pushed and the previous-`ia` register is not built.

## Structure
- `beta_trace_pkg` holds:
  - `trace_rec_t`, a packed struct with fields `cntl[3:0]`, `ia`, `memAddr`, `memWriteData`, 100 bits total;
  - constants `CNTL_RESET_BIT` = 2, `CNTL_MEMREAD_BIT` = 1, `CNTL_MEMWRITE_BIT` = 0;
  - `TRACE_W` = 100.
- Sub-module `trace_fifo`: a generic FWFT synchronous FIFO parameterized on `DEPTH` and `trace_rec_t`, with push/pop/clear, count, full and empty.
- The top level owns record packing, the filter, overflow and `dropCount`.

## Test plan
- Reset, then `captureEn` = 1 for 3 cycles with `ia` = 0x0, 0x4, 0x8, `MemRead` = 1, `memAddr` = 0x100, `traceReady` = 0. Then raise `traceReady`. Expected: `count` = 3, followed by records with `traceData[99:96]` = 4'b0010 and `ia` 0x0, 0x4, 0x8 in order on consecutive cycles, after which `traceValid` = 0.
- Fill `DEPTH` = 4 with `traceReady` = 0, then push 2 more. Expected: `full` = 1, `overflow` = 1, `dropCount` = 2, and the 4 retained records are the first 4.
- With the FIFO full, push and pop together for 5 cycles. Expected: `count` stays 4, no drops, and output order is preserved.
- Assert `reset` asynchronously mid-drain with 3 entries buffered. Expected: `traceValid` and `count` go to 0 before the next edge. Records captured after reset release start at a fresh head.
- Assert `clear` together with `captureEn` and a pop. Expected: `count` = 0, `overflow` = 0, `dropCount` = 0 on the next cycle, and no record is stored.
- With `BETA_TRACE_FILTER_EN` defined, drive `ia` 0x0, 0x4, 0x8, 0x40, 0x44 with no strobes. Expected: exactly 2 records, with `ia` = 0x0 (break from reset value … 0x0 = 0+4 fails → record) and `ia` = 0x40 (branch).

Source files
------------

// File: rtl/beta_trace_pkg.sv
// Shared types and constants for the Beta trace recorder.
// Record layout matches the Beta bench golden-vector format: {cntl, ia, memAddr, memWriteData}.
// No ports; imported by trace_fifo and beta_trace_recorder.
package beta_trace_pkg;

    localparam int TRACE_W = 100;

    // Bit positions inside trace_rec_t.cntl; bit 3 is always zero.
    localparam int CNTL_RESET_BIT    = 2;
    localparam int CNTL_MEMREAD_BIT  = 1;
    localparam int CNTL_MEMWRITE_BIT = 0;

    typedef struct packed {
        logic [3:0]  cntl;
        logic [31:0] ia;
        logic [31:0] memAddr;
        logic [31:0] memWriteData;
    } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// Generic first-word-fall-through synchronous FIFO of trace records.
// Latency: a push at edge N is visible on rd_data after edge N. Pop advances the head at the edge.
// Backpressure: push while full is refused unless a pop happens in the same cycle; pop while empty is ignored.
// Ports: clk, reset (async high), push, pop, clear (sync flush), wr_data, rd_data, count, full, empty.
module trace_fifo
    import beta_trace_pkg::*;
#(
    parameter int  DEPTH = 64,
    parameter type T     = trace_rec_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  T                       wr_data,
    output T                       rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    T mem [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
    assign do_push = push && (!full || do_pop);

    // Empty FIFO presents zeros so the head never exposes uninitialised storage.
    assign rd_data = empty ? T'('0) : mem[head];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_pop)  head <= head + 1'b1;
            if (do_push) tail <= tail + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[tail] <= wr_data;
    end

endmodule

// File: rtl/beta_trace_recorder.sv
// Beta bus trace recorder: packs per-cycle bus activity into 100-bit records and buffers them for a host.
// Latency: capture to traceValid is 1 cycle; drain runs at 1 record/cycle while traceReady is high.
// Backpressure: records arriving while full (no pop) are dropped, setting overflow and bumping dropCount.
// Ports: clk, reset (async high), captureEn, clear, cpuReset, ia, memAddr, memWriteData, MemRead, MemWrite,
//        traceData/traceValid/traceReady (host drain), count, full, overflow, dropCount.
// Optional feature: define BETA_TRACE_FILTER_EN to record only strobe, cpuReset or non-sequential-ia cycles.
module beta_trace_recorder
    import beta_trace_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   captureEn,
    input  logic                   clear,
    input  logic                   cpuReset,
    input  logic [31:0]            ia,
    input  logic [31:0]            memAddr,
    input  logic [31:0]            memWriteData,
    input  logic                   MemRead,
    input  logic                   MemWrite,
    output logic [TRACE_W-1:0]     traceData,
    output logic                   traceValid,
    input  logic                   traceReady,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   overflow,
    output logic [CNT_W-1:0]       dropCount
);

    trace_rec_t rec;
    trace_rec_t head_rec;
    logic       push_req;
    logic       pop_req;
    logic       empty;
    logic       drop;

    always_comb begin
        rec                         = '0;
        rec.cntl[CNTL_RESET_BIT]    = cpuReset;
        rec.cntl[CNTL_MEMREAD_BIT]  = MemRead;
        rec.cntl[CNTL_MEMWRITE_BIT] = MemWrite;
        rec.ia                      = ia;
        rec.memAddr                 = memAddr;
        rec.memWriteData            = memWriteData;
    end

`ifdef BETA_TRACE_FILTER_EN
    // Tracks ia every cycle so sequential fetches are suppressed even across capture gaps.
    logic [31:0] prev_ia;
    logic        ia_break;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) prev_ia <= '0;
        else       prev_ia <= ia;
    end

    assign ia_break = (ia != prev_ia + 32'd4);
    assign push_req = captureEn && (MemRead || MemWrite || cpuReset || ia_break);
`else
    assign push_req = captureEn;
`endif

    assign traceValid = !empty;
    assign pop_req    = traceValid && traceReady;
    assign traceData  = head_rec;

    // A same-cycle pop makes room, so only a full FIFO without a pop drops.
    assign drop = push_req && full && !pop_req && !clear;

    trace_fifo #(
        .DEPTH (DEPTH),
        .T     (trace_rec_t)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_req),
        .pop     (pop_req),
        .clear   (clear),
        .wr_data (rec),
        .rd_data (head_rec),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            dropCount <= '0;
        end else if (clear) begin
            overflow  <= 1'b0;
            dropCount <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (dropCount != '1) dropCount <= dropCount + 1'b1;
        end
    end

endmodule
